// File: rtl/cvmcu_cpi_rx_packer_if.sv
// ---------------------------------------------------------------------------
// cvmcu_cpi_rx_packer_if
// Output word stream of the CPI receive packer.
//   data_o  : packed 32-bit pixel word (producer -> consumer)
//   valid_o : data_o/sof_o valid (producer -> consumer)
//   sof_o   : word is the first of a frame (producer -> consumer)
//   ready_i : consumer accepts the word when valid_o && ready_i
// master = packer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface cvmcu_cpi_rx_packer_if;
  logic [31:0] data_o;
  logic        valid_o;
  logic        sof_o;
  logic        ready_i;

  modport master (
    output data_o,
    output valid_o,
    output sof_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    input  sof_o,
    output ready_i
  );
endinterface

// File: rtl/cvmcu_cpi_rx_packer.sv
// ---------------------------------------------------------------------------
// cvmcu_cpi_rx_packer
// Captures pixels from a Camera Parallel Interface, packs them little-endian
// into 32-bit words and queues the words in a small FIFO for a ready/valid
// consumer. Also counts lines per frame and completed frames.
//
// Ports:
//   clk_i        sole clock, rising edge
//   rst_i        asynchronous active-high reset
//   en_i         capture enable; low forces IDLE and drops the partial word
//   clr_i        one-cycle pulse, clears ovf_o and frame_cnt_o
//   cam_data_i   pixel data (DATA_WIDTH bits, 8 or 16)
//   cam_hsync_i  high = pixel valid / line active
//   cam_vsync_i  high = frame active
//   out_if       word stream (data_o, valid_o, sof_o, ready_i)
//   line_cnt_o   completed lines in the current frame, saturating
//   frame_cnt_o  completed frames, wrapping
//   ovf_o        sticky FIFO overflow flag
//
// FSM
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | capture disabled, packer cleared
//   ST_WAIT    | enabled, waiting for a vsync rising edge to start a frame
//   ST_FRAME   | inside a frame, capturing pixels while hsync is high
// ---------------------------------------------------------------------------
module cvmcu_cpi_rx_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] cam_data_i,
  input  logic                  cam_hsync_i,
  input  logic                  cam_vsync_i,
  cvmcu_cpi_rx_packer_if.master out_if,
  output logic [15:0]           line_cnt_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  ovf_o
);

  // Parameter legality
  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16)) begin : g_bad_data_width
    $error("cvmcu_cpi_rx_packer: DATA_WIDTH must be 8 or 16");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("cvmcu_cpi_rx_packer: FIFO_DEPTH must be a power of two in 2..16");
  end

  localparam int          PIX_PER_WORD = 32 / DATA_WIDTH;
  localparam logic [1:0]  LAST_IDX     = 2'(PIX_PER_WORD - 1);
  localparam int          PTR_W        = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE   = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;

  // -------------------------------------------------------------------------
  // Input stage S0 and its delayed copy for edge detection
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] data_s0_q;
  logic                  hs_s0_q, vs_s0_q;
  logic                  hs_s1_q, vs_s1_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_s0_q <= '0;
      hs_s0_q   <= 1'b0;
      vs_s0_q   <= 1'b0;
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
    end else begin
      data_s0_q <= cam_data_i;
      hs_s0_q   <= cam_hsync_i;
      vs_s0_q   <= cam_vsync_i;
      hs_s1_q   <= hs_s0_q;
      vs_s1_q   <= vs_s0_q;
    end
  end

  logic vs_rise, vs_fall, hs_fall;
  assign vs_rise = vs_s0_q & ~vs_s1_q;
  assign vs_fall = ~vs_s0_q & vs_s1_q;
  assign hs_fall = ~hs_s0_q & hs_s1_q;

  // -------------------------------------------------------------------------
  // Packer datapath
  // -------------------------------------------------------------------------
  logic [1:0]  state_q;
  logic [1:0]  idx_q;
  logic [31:0] pack_q;
  logic        sof_pend_q;

  logic        in_frame;
  logic        cap;
  logic        flush;
  logic [31:0] pack_next;
  logic        wr_en;
  logic [32:0] wr_word;

  always_comb begin
    in_frame  = (state_q == ST_FRAME) && en_i;
    cap       = in_frame && hs_s0_q;
    flush     = in_frame && (hs_fall || vs_fall);
    pack_next = pack_q;
    if (cap) begin
      pack_next = pack_q | (32'(data_s0_q) << (DATA_WIDTH * idx_q));
    end
    // A flush on vsync fall may coincide with a captured pixel (hsync still
    // high), so the word is non-empty if either pixels were pending or one
    // arrives this cycle.
    wr_en   = (cap && (idx_q == LAST_IDX)) ||
              (flush && (cap || (idx_q != 2'd0)));
    wr_word = {sof_pend_q, pack_next};
  end

  // -------------------------------------------------------------------------
  // FSM, packer state and line counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      pack_q     <= '0;
      sof_pend_q <= 1'b0;
      line_cnt_o <= '0;
    end else if (!en_i) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      pack_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (vs_rise) begin
            state_q    <= ST_FRAME;
            idx_q      <= 2'd0;
            pack_q     <= '0;
            sof_pend_q <= 1'b1;
            line_cnt_o <= '0;
          end
        end
        ST_FRAME: begin
          if (wr_en) begin
            idx_q      <= 2'd0;
            pack_q     <= '0;
            sof_pend_q <= 1'b0;
          end else if (cap) begin
            idx_q  <= idx_q + 2'd1;
            pack_q <= pack_next;
          end
          if (hs_fall && (line_cnt_o != 16'hFFFF)) begin
            line_cnt_o <= line_cnt_o + 16'd1;
          end
          if (vs_fall) begin
            state_q <= ST_WAIT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO (no bypass: a word written this cycle is visible next cycle)
  // -------------------------------------------------------------------------
  logic [32:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
  logic           empty, full, pop, push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop   = !empty && out_if.ready_i;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer addresses.
  assign push  = wr_en && (!full || pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_word;
    end
  end

  logic [32:0] head;
  assign head = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Gated so outputs read zero whenever nothing is queued, including reset.
  assign out_if.valid_o = !empty;
  assign out_if.data_o  = empty ? 32'd0 : head[31:0];
  assign out_if.sof_o   = empty ? 1'b0 : head[32];

  // -------------------------------------------------------------------------
  // Frame counter and sticky overflow; clear wins over set/increment
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_o <= '0;
      ovf_o       <= 1'b0;
    end else begin
      if (clr_i) begin
        frame_cnt_o <= '0;
      end else if (in_frame && vs_fall) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
      if (clr_i) begin
        ovf_o <= 1'b0;
      end else if (wr_en && full && !pop) begin
        ovf_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cvmcu_cpi_rx_packer.sv
module tb_cvmcu_cpi_rx_packer;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i, clr_i, hs, vs, rdy;
  logic [15:0] cam_d;
  logic [15:0] lc [2];
  logic [15:0] fc [2];
  logic        ov [2];
  logic        vo [2];
  logic        so [2];
  logic [31:0] dq [2];

  always #5 clk_i = ~clk_i;

  cvmcu_cpi_rx_packer_if if0 ();
  cvmcu_cpi_rx_packer_if if1 ();
  assign if0.ready_i = rdy;
  assign if1.ready_i = rdy;
  assign vo[0] = if0.valid_o; assign so[0] = if0.sof_o; assign dq[0] = if0.data_o;
  assign vo[1] = if1.valid_o; assign so[1] = if1.sof_o; assign dq[1] = if1.data_o;

  cvmcu_cpi_rx_packer #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i),
    .cam_data_i(cam_d[7:0]), .cam_hsync_i(hs), .cam_vsync_i(vs),
    .out_if(if0.master), .line_cnt_o(lc[0]), .frame_cnt_o(fc[0]), .ovf_o(ov[0]));

  cvmcu_cpi_rx_packer #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i),
    .cam_data_i(cam_d), .cam_hsync_i(hs), .cam_vsync_i(vs),
    .out_if(if1.master), .line_cnt_o(lc[1]), .frame_cnt_o(fc[1]), .ovf_o(ov[1]));

  int checks = 0;
  int failures = 0;
  bit chk_on = 0;
  bit rnd_rdy = 0;
  bit rnd_clr = 0;

  task automatic chk(input string nm, input int k, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (one per instance) ----------------
  // Frame mode: 0 disabled, 1 waiting for frame start, 2 in frame.
  int          m_mode [2];
  bit          m_s0v [2], m_s1v [2], m_s0h [2], m_s1h [2];
  logic [15:0] m_s0d [2];
  logic [31:0] m_acc [2];
  int          m_n [2];
  bit          m_sofp [2];
  logic [15:0] m_line [2], m_frame [2];
  bit          m_ovf [2];
  logic [32:0] m_buf [2][DEPTH];
  int          m_head [2], m_cnt [2];

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_s0v[k] = 0; m_s1v[k] = 0; m_s0h[k] = 0; m_s1h[k] = 0;
      m_s0d[k] = '0; m_acc[k] = '0; m_n[k] = 0; m_sofp[k] = 0;
      m_line[k] = '0; m_frame[k] = '0; m_ovf[k] = 0; m_head[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic mstep(input int k);
    int dw;
    bit vr, vf, hf, wr, pop;
    logic [32:0] w;
    logic [15:0] pix;
    dw  = (k == 0) ? 8 : 16;
    vr  = m_s0v[k] && !m_s1v[k];
    vf  = !m_s0v[k] && m_s1v[k];
    hf  = !m_s0h[k] && m_s1h[k];
    pix = (k == 0) ? {8'h00, m_s0d[k][7:0]} : m_s0d[k];
    pop = (m_cnt[k] > 0) && rdy;
    wr  = 0;
    w   = '0;
    if (!en_i) begin
      m_mode[k] = 0; m_n[k] = 0; m_acc[k] = '0;
    end else if (m_mode[k] == 0) begin
      m_mode[k] = 1;
    end else if (m_mode[k] == 1) begin
      if (vr) begin
        m_mode[k] = 2; m_line[k] = '0; m_n[k] = 0; m_acc[k] = '0; m_sofp[k] = 1;
      end
    end else begin
      if (m_s0h[k]) begin
        m_acc[k] = m_acc[k] | (32'(pix) << (dw * m_n[k]));
        m_n[k]++;
      end
      if (m_n[k] == 32 / dw || ((hf || vf) && m_n[k] > 0)) begin
        wr = 1; w = {m_sofp[k], m_acc[k]};
        m_sofp[k] = 0; m_n[k] = 0; m_acc[k] = '0;
      end
      if (hf && m_line[k] != 16'hFFFF) m_line[k] = m_line[k] + 16'd1;
      if (vf) begin
        m_frame[k] = m_frame[k] + 16'd1;
        m_mode[k] = 1;
      end
    end
    if (pop) begin
      m_head[k] = (m_head[k] + 1) % DEPTH;
      m_cnt[k]--;
    end
    if (wr) begin
      if (m_cnt[k] < DEPTH) begin
        m_buf[k][(m_head[k] + m_cnt[k]) % DEPTH] = w;
        m_cnt[k]++;
      end else begin
        m_ovf[k] = 1;
      end
    end
    if (clr_i) begin
      m_frame[k] = '0; m_ovf[k] = 0;
    end
    m_s1v[k] = m_s0v[k]; m_s1h[k] = m_s0h[k];
    m_s0v[k] = vs; m_s0h[k] = hs; m_s0d[k] = cam_d;
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mreset();
    else begin
      mstep(0);
      mstep(1);
    end
  end

  // ---------------- per-cycle compare + accepted-word logs ----------------
  logic [32:0] log0 [$];
  logic [32:0] log1 [$];

  always @(negedge clk_i) begin
    if (!rst_i && chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk("valid", k, 33'(vo[k]), 33'(m_cnt[k] != 0));
        if (m_cnt[k] != 0) begin
          chk("data", k, 33'(dq[k]), 33'(m_buf[k][m_head[k]][31:0]));
          chk("sof", k, 33'(so[k]), 33'(m_buf[k][m_head[k]][32]));
        end
        chk("line_cnt", k, 33'(lc[k]), 33'(m_line[k]));
        chk("frame_cnt", k, 33'(fc[k]), 33'(m_frame[k]));
        chk("ovf", k, 33'(ov[k]), 33'(m_ovf[k]));
      end
      if (vo[0] && rdy) log0.push_back({so[0], dq[0]});
      if (vo[1] && rdy) log1.push_back({so[1], dq[1]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;
    if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
    if (rnd_clr) clr_i = ($urandom_range(0, 63) == 0);
  endtask

  task automatic idle_n(input int n);
    hs = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pixel(input logic [15:0] d);
    hs = 1'b1;
    cam_d = d;
    tick();
  endtask

  task automatic send_line(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) pixel(base + 16'(i));
    hs = 1'b0;
    tick();
  endtask

  task automatic outs_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_valid"}, k, 33'(vo[k]), 33'd0);
      chk({tag, "_sof"}, k, 33'(so[k]), 33'd0);
      chk({tag, "_data"}, k, 33'(dq[k]), 33'd0);
      chk({tag, "_ovf"}, k, 33'(ov[k]), 33'd0);
      chk({tag, "_line"}, k, 33'(lc[k]), 33'd0);
      chk({tag, "_frame"}, k, 33'(fc[k]), 33'd0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_i = 1'b1; en_i = 1'b0; clr_i = 1'b0; hs = 1'b0; vs = 1'b0;
    rdy = 1'b1; cam_d = '0;
    repeat (3) @(posedge clk_i);
    #1;
    outs_zero("reset");
    rst_i = 1'b0;
    chk_on = 1;

    // One 8-pixel line, ready high
    en_i = 1'b1;
    idle_n(3);
    vs = 1'b1;
    idle_n(2);
    send_line(8, 16'h0001);
    idle_n(6);
    chk("l1_count", 0, 33'(log0.size()), 33'd2);
    if (log0.size() >= 2) begin
      chk("l1_w0", 0, log0[0], 33'h1_04030201);
      chk("l1_w1", 0, log0[1], 33'h0_08070605);
    end
    chk("l1_line_cnt", 0, 33'(lc[0]), 33'd1);

    // Six-pixel line leaves a padded partial word
    send_line(6, 16'h00A1);
    idle_n(6);
    chk("l2_count", 0, 33'(log0.size()), 33'd4);
    if (log0.size() >= 4) begin
      chk("l2_w0", 0, log0[2], 33'h0_A4A3A2A1);
      chk("l2_w1", 0, log0[3], 33'h0_0000A6A5);
    end
    vs = 1'b0;
    idle_n(4);
    chk("f1_frame_cnt", 0, 33'(fc[0]), 33'd1);

    // 16-bit: 2 lines x 3 pixels
    clr_i = 1'b1;
    tick();
    log1.delete();
    vs = 1'b1;
    idle_n(2);
    pixel(16'h1111); pixel(16'h2222); pixel(16'h3333);
    idle_n(2);
    pixel(16'h4444); pixel(16'h5555); pixel(16'h6666);
    idle_n(2);
    vs = 1'b0;
    idle_n(6);
    chk("dw16_count", 1, 33'(log1.size()), 33'd4);
    if (log1.size() >= 4) begin
      chk("dw16_w0", 1, log1[0], 33'h1_22221111);
      chk("dw16_w1", 1, log1[1], 33'h0_00003333);
      chk("dw16_w2", 1, log1[2], 33'h0_55554444);
      chk("dw16_w3", 1, log1[3], 33'h0_00006666);
    end
    chk("dw16_frame_cnt", 1, 33'(fc[1]), 33'd1);

    // Overflow: 20 pixels with ready low
    log0.delete();
    rdy = 1'b0;
    vs = 1'b1;
    idle_n(2);
    send_line(20, 16'h0010);
    idle_n(4);
    vs = 1'b0;
    idle_n(4);
    chk("ovf_set", 0, 33'(ov[0]), 33'd1);
    rdy = 1'b1;
    idle_n(8);
    chk("ovf_count", 0, 33'(log0.size()), 33'd4);
    if (log0.size() >= 4) begin
      chk("ovf_w0", 0, log0[0], 33'h1_13121110);
      chk("ovf_w1", 0, log0[1], 33'h0_17161514);
      chk("ovf_w2", 0, log0[2], 33'h0_1B1A1918);
      chk("ovf_w3", 0, log0[3], 33'h0_1F1E1D1C);
    end
    clr_i = 1'b1;
    tick();
    chk("ovf_clr", 0, 33'(ov[0]), 33'd0);

    // Enable while vsync already high, then drop enable mid-line
    log0.delete();
    en_i = 1'b0;
    tick();
    vs = 1'b1;
    idle_n(3);
    en_i = 1'b1;
    idle_n(3);
    send_line(8, 16'h0050);
    idle_n(6);
    chk("no_word_vs_high", 0, 33'(log0.size()), 33'd0);
    vs = 1'b0;
    idle_n(3);
    vs = 1'b1;
    idle_n(2);
    pixel(16'h0061); pixel(16'h0062);
    en_i = 1'b0;
    hs = 1'b0;
    tick();
    idle_n(6);
    chk("no_partial", 0, 33'(log0.size()), 33'd0);
    vs = 1'b0;
    en_i = 1'b1;
    idle_n(3);

    // Reset mid-line with a full FIFO
    rdy = 1'b0;
    vs = 1'b1;
    idle_n(2);
    for (int i = 0; i < 18; i++) pixel(16'h0070 + 16'(i));
    chk("pre_reset_full", 0, 33'(vo[0]), 33'd1);
    #2;
    rst_i = 1'b1;
    #1;
    outs_zero("async_rst");
    en_i = 1'b0; hs = 1'b0; vs = 1'b0; rdy = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    log0.delete();
    en_i = 1'b1;
    idle_n(3);
    vs = 1'b1;
    idle_n(2);
    send_line(4, 16'h0031);
    idle_n(6);
    chk("post_rst_count", 0, 33'(log0.size()), 33'd1);
    if (log0.size() >= 1) chk("post_rst_w0", 0, log0[0], 33'h1_34333231);
    chk("post_rst_line", 0, 33'(lc[0]), 33'd1);
    vs = 1'b0;
    idle_n(3);

    // Randomized frames against the model
    rnd_rdy = 1;
    rnd_clr = 1;
    for (int f = 0; f < 40; f++) begin
      vs = 1'b0;
      idle_n($urandom_range(1, 4));
      vs = 1'b1;
      idle_n($urandom_range(0, 3));
      for (int l = 0; l < int'($urandom_range(1, 4)); l++) begin
        for (int p = 0; p < int'($urandom_range(0, 10)); p++) begin
          pixel(16'($urandom));
          if ($urandom_range(0, 40) == 0) begin
            en_i = 1'b0;
            tick();
            en_i = 1'b1;
          end
        end
        idle_n($urandom_range(1, 3));
      end
    end
    vs = 1'b0;
    rnd_rdy = 0;
    rnd_clr = 0;
    rdy = 1'b1;
    idle_n(20);
    chk("drained0", 0, 33'(vo[0]), 33'd0);
    chk("drained1", 1, 33'(vo[1]), 33'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
